// File: rtl/snn_cfg_pkg.sv
// Shared definitions for the SNN configuration bank: opcodes, FSM states,
// default geometry and a saturating address increment.
package snn_cfg_pkg;

  localparam int          DEFAULT_CFG_BYTES   = 320;
  localparam int          DEFAULT_NUM_REGIONS = 4;
  localparam logic [63:0] DEFAULT_REGION_BASE = {16'd319, 16'd7, 16'd3, 16'd0};

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_COMMIT = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_WRITE,
    ST_READ,
    ST_COMMIT,
    ST_DRAIN
  } state_e;

  // Once the pointer reaches 0xFFFF it stays there, so it can never wrap back in range.
  function automatic logic [15:0] sat_inc(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

endpackage

// File: rtl/cfg_region_lookup.sv
// Combinational address-to-region decode: picks the highest region whose
// base address is at or below the given address.
module cfg_region_lookup #(
  parameter int                          NUM_REGIONS = 4,
  parameter int                          IDX_W       = 2,
  parameter logic [16*NUM_REGIONS-1:0]   REGION_BASE = {16'd319, 16'd7, 16'd3, 16'd0}
) (
  input  logic [15:0]      addr,
  output logic [IDX_W-1:0] region
);

  // Region 0 always starts at zero, so it is the fallback and needs no compare.
  always_comb begin
    region = '0;
    for (int r = 1; r < NUM_REGIONS; r++) begin
      if (addr >= REGION_BASE[16*r +: 16]) region = IDX_W'(r);
    end
  end

endmodule

// File: rtl/snn_cfg_bank.sv
// Double-buffered configuration store: framed byte commands write a shadow
// array, read it back, and commit it atomically to the active array.
module snn_cfg_bank
  import snn_cfg_pkg::*;
#(
  parameter int                        CFG_BYTES   = DEFAULT_CFG_BYTES,
  parameter int                        NUM_REGIONS = DEFAULT_NUM_REGIONS,
  parameter logic [16*NUM_REGIONS-1:0] REGION_BASE = DEFAULT_REGION_BASE
) (
  input  logic                     system_clock,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     frame_end,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  output logic [8*CFG_BYTES-1:0]   cfg_active,
  output logic [NUM_REGIONS-1:0]   region_update,
  output logic                     busy,
  output logic                     err
);

  localparam int          AW        = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
  localparam int          IDX_W     = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [16:0] CFG_LIMIT = 17'(CFG_BYTES);

  state_e                 state_q, state_d;
  logic [15:0]            addr_q, addr_d;
  logic [7:0]             addr_hi_q, addr_hi_d;
  logic                   is_read_q, is_read_d;
  logic [7:0]             shadow_q [CFG_BYTES];
  logic [7:0]             shadow_d [CFG_BYTES];
  logic [7:0]             active_q [CFG_BYTES];
  logic [7:0]             active_d [CFG_BYTES];
  logic [NUM_REGIONS-1:0] dirty_q, dirty_d;
  logic [NUM_REGIONS-1:0] region_update_q, region_update_d;
  logic                   err_q, err_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   pend_start_q, pend_start_d;
  logic                   pend_end_q, pend_end_d;

  logic                   rx_fire;
  logic                   wr_in_range;
  logic [IDX_W-1:0]       wr_region;
  logic [15:0]            rd_addr;
  logic [7:0]             rd_data;

  cfg_region_lookup #(
    .NUM_REGIONS (NUM_REGIONS),
    .IDX_W       (IDX_W),
    .REGION_BASE (REGION_BASE)
  ) u_region_lookup (
    .addr   (addr_q),
    .region (wr_region)
  );

  assign rx_ready    = reset && (state_q != ST_COMMIT);
  assign rx_fire     = rx_valid && rx_ready;
  assign wr_in_range = ({1'b0, addr_q} < CFG_LIMIT);

  // Read port feeds both the first byte (address just completed) and each following byte.
  always_comb begin
    rd_addr = (state_q == ST_ADDR_LO) ? {addr_hi_q, rx_data} : sat_inc(addr_q);
    rd_data = ({1'b0, rd_addr} < CFG_LIMIT) ? shadow_q[rd_addr[AW-1:0]] : 8'h00;
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    addr_hi_d       = addr_hi_q;
    is_read_d       = is_read_q;
    shadow_d        = shadow_q;
    active_d        = active_q;
    dirty_d         = dirty_q;
    region_update_d = '0;
    err_d           = err_q;
    tx_valid_d      = tx_valid_q;
    tx_data_d       = tx_data_q;
    pend_start_d    = 1'b0;
    pend_end_d      = 1'b0;

    unique case (state_q)
      ST_HDR: if (rx_fire) begin
        if (rx_data == OP_WRITE || rx_data == OP_READ) begin
          is_read_d = (rx_data == OP_READ);
          state_d   = ST_ADDR_HI;
        end else if (rx_data == OP_COMMIT) begin
          state_d      = ST_COMMIT;
          pend_start_d = frame_start;
          pend_end_d   = frame_end;
        end else begin
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_ADDR_HI: if (rx_fire) begin
        addr_hi_d = rx_data;
        state_d   = ST_ADDR_LO;
      end
      ST_ADDR_LO: if (rx_fire) begin
        addr_d = {addr_hi_q, rx_data};
        if (is_read_q) begin
          state_d    = ST_READ;
          tx_valid_d = 1'b1;
          tx_data_d  = rd_data;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: if (rx_fire) begin
        if (wr_in_range) begin
          shadow_d[addr_q[AW-1:0]] = rx_data;
          dirty_d[wr_region]       = 1'b1;
          addr_d                   = sat_inc(addr_q);
        end else begin
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_READ: if (tx_valid_q && tx_ready) begin
        addr_d    = sat_inc(addr_q);
        tx_data_d = rd_data;
      end
      ST_COMMIT: begin
        active_d        = shadow_q;
        region_update_d = dirty_q;
        dirty_d         = '0;
        err_d           = 1'b0;
        if (frame_start || pend_start_q)  state_d = ST_HDR;
        else if (frame_end || pend_end_q) state_d = ST_IDLE;
        else                              state_d = ST_DRAIN;
      end
      default: ;
    endcase

    // Frame boundaries override everything except a commit that is about to run.
    if (state_q != ST_COMMIT && state_d != ST_COMMIT) begin
      if (frame_start)    state_d = ST_HDR;
      else if (frame_end) state_d = ST_IDLE;
    end
    if (state_d != ST_READ) tx_valid_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only; the arrays are
  // reset as well because a mid-frame reset must leave cfg_active all zero.
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      addr_hi_q       <= '0;
      is_read_q       <= 1'b0;
      shadow_q        <= '{default: '0};
      active_q        <= '{default: '0};
      dirty_q         <= '0;
      region_update_q <= '0;
      err_q           <= 1'b0;
      tx_valid_q      <= 1'b0;
      tx_data_q       <= '0;
      pend_start_q    <= 1'b0;
      pend_end_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      addr_hi_q       <= addr_hi_d;
      is_read_q       <= is_read_d;
      shadow_q        <= shadow_d;
      active_q        <= active_d;
      dirty_q         <= dirty_d;
      region_update_q <= region_update_d;
      err_q           <= err_d;
      tx_valid_q      <= tx_valid_d;
      tx_data_q       <= tx_data_d;
      pend_start_q    <= pend_start_d;
      pend_end_q      <= pend_end_d;
    end
  end

  for (genvar i = 0; i < CFG_BYTES; i++) begin : g_active
    assign cfg_active[8*i +: 8] = active_q[i];
  end

  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign region_update = region_update_q;
  assign busy          = (state_q != ST_IDLE);
  assign err           = err_q;

endmodule

// File: doc/snn_cfg_bank.md
# snn_cfg_bank

Parametrised, double-buffered configuration store for the spiking network. It sits between the SPI byte deserialiser and the SNN core, clock divider and debug module. Configuration bytes are written into a shadow array by framed commands and copied atomically to the active array on a commit command. Per-region update strobes replace the fixed per-field ready flags, and the block supports addressed writes, readback and error reporting.

## Interface
Parameters:
- CFG_BYTES, 320, total configuration bytes; must be ≤ 65536.
- NUM_REGIONS, 4, number of contiguous address regions that get update strobes.
- REGION_BASE, {16'd319,16'd7,16'd3,16'd0}, flat vector of region start addresses, region 0 in the LSBs. Bases must be strictly ascending and region 0 base = 0. Region r spans base_r..base_{r+1}-1; the last region ends at CFG_BYTES-1.

Ports:
- system_clock  input  1  sole clock.
- reset  input  1  asynchronous, active-low reset.
- frame_start  input  1  one-cycle pulse at start of frame (SS assert, already synchronised).
- frame_end  input  1  one-cycle pulse at end of frame.
- rx_valid  input  1  received byte valid.
- rx_data  input  8  received byte.
- rx_ready  output  1  byte accept; transfer occurs when rx_valid & rx_ready.
- tx_valid  output  1  readback byte valid.
- tx_data  output  8  readback byte.
- tx_ready  input  1  readback byte consumed.
- cfg_active  output  8*CFG_BYTES  active configuration; byte a is at [8a+7:8a].
- region_update  output  NUM_REGIONS  one-cycle strobes, issued on commit.
- busy  output  1  high whenever state ≠ IDLE.
- err  output  1  sticky error flag, cleared by reset or a successful commit.

## Operation
- Command byte is the first accepted byte of a frame: 0x01 WRITE, 0x02 READ, 0x03 COMMIT. Any other value sets err and moves to DRAIN.
- WRITE: header, addr_hi, addr_lo, then data bytes.
  - Each data byte goes to shadow[addr], sets dirty[region(addr)], and increments addr.
  - A data byte with addr ≥ CFG_BYTES is discarded, sets err, and moves to DRAIN.
- READ: header, addr_hi, addr_lo, then tx streams shadow[addr], shadow[addr+1], and so on.
  - Addresses ≥ CFG_BYTES return 0x00 and do not set err.
  - rx bytes received during READ are accepted and discarded (full duplex).
- COMMIT: on acceptance of the header, go to COMMIT for exactly one cycle.
  - In that cycle: cfg_active ← shadow, region_update ← dirty, dirty ← 0, err ← 0.
  - Then go to DRAIN.
- States: IDLE, HDR, ADDR_HI, ADDR_LO, WRITE, READ, COMMIT, DRAIN.
  - IDLE→HDR on frame_start.
  - HDR→ADDR_HI on 0x01 or 0x02; HDR→COMMIT on 0x03.
  - ADDR_HI→ADDR_LO→WRITE or READ.
  - From any state except COMMIT: frame_end → IDLE; frame_start → HDR (aborts the current frame).
- Simultaneous rx transfer and frame_end: the byte is processed first (write lands), then the next state is IDLE.
- Frame ending before addr_lo: no write occurs and err is not set.
- Bytes received in IDLE or DRAIN are accepted and ignored.
- A frame_end or frame_start arriving during COMMIT is acted on in the following cycle.
- Width rules:
  - addr is 16 bits, formed as {addr_hi, addr_lo}.
  - Increment saturates at 0xFFFF; once out of range it stays out of range.

## Timing
- Reset values: shadow, cfg_active, dirty and addr are all zero. tx_data = 0x00. tx_valid = 0, region_update = 0, err = 0, busy = 0. rx_ready is 0 while reset is asserted.
- rx_ready = 1 in every state except COMMIT.
- Write latency: a shadow byte is updated on the clock edge that accepts it. cfg_active changes only at the end of the COMMIT cycle. region_update is high for the cycle immediately after COMMIT.
- READ flow:
  - tx_valid rises the cycle after addr_lo is accepted, with tx_data registered.
  - On tx_valid & tx_ready, the next byte is presented the following cycle. tx_valid stays high until leaving READ.
  - tx_data is stable while tx_valid & !tx_ready.
- Reset mid-frame returns immediately to IDLE with all state cleared. cfg_active is zeroed.

## Structure
- Package snn_cfg_pkg holds: opcode constants (OP_WRITE, OP_READ, OP_COMMIT), the state enum, and the default REGION_BASE and CFG_BYTES.
- Sub-module cfg_region_lookup: combinational address→region index over REGION_BASE, instantiated once on the write address.

## Test plan
- Write frame 01 00 28 AA BB, then commit frame 03 → cfg_active byte 40 = 0xAA and byte 41 = 0xBB, region_update = 4'b0100 for one cycle, err = 0.
- Write 01 00 05 11, no commit → cfg_active byte 5 stays 0x00; READ 02 00 05 → tx_data = 0x11.
- Write 01 01 3F 55 66 (addresses 319 and 320) → byte 319 is written, err = 1, and byte 320 is dropped. A following commit gives region_update = 4'b1000 and clears err.
- Header 0x7E → err = 1; subsequent bytes are ignored until frame_end; busy then falls.
- frame_start mid-WRITE after addr_hi only → aborted, no byte is written, and the new header is decoded correctly.
- Assert reset during READ streaming → tx_valid = 0, cfg_active = 0, state IDLE on the next edge.
